mem_access_arbiter: RTL and testbench

- Sequences and shares the 32x8 scratch memory between NREQ requesters, e.g. fetch unit and load/store unit.
- Arbitrates round-robin and latches the winner's command.
- Drives the memory's address, write data and read/write strobe with clean setup and strobe phases, then returns read data with a one-cycle ack.
- Sits between the requesters and the memory; it is the only driver of the memory pins.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/mem_access_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory access arbiter: FSM state encoding,
// default memory geometry and the rotating-priority search.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WAIT   = 3'd2,
    STROBE = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 8;
  localparam int MAX_NREQ = 4;

  // First set bit of req at or after ptr, wrapping modulo n (n <= MAX_NREQ).
  // Returns ptr when no bit is set; callers qualify with |req.
  function automatic logic [1:0] rot_first_one(input logic [MAX_NREQ-1:0] req,
                                                input logic [1:0]          ptr,
                                                input logic [2:0]          n);
    logic [2:0] idx;
    rot_first_one = ptr;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= n) idx = idx - n;
      if ((3'(k) < n) && req[idx[1:0]]) rot_first_one = idx[1:0];
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot and binary winner starting the
// search at ptr. The pointer itself is owned by the instantiating block.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [MAX_NREQ-1:0] req_ext;
  logic [1:0]          ptr_ext;
  logic [1:0]          win;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    ptr_ext            = 2'(ptr);
    win                = rot_first_one(req_ext, ptr_ext, 3'(NREQ));
    idx                = IW'(win);
    grant              = '0;
    if (en && (|req)) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin sharing of one scratch-memory port between NREQ requesters.
// Optional write protection at and above PROT_BASE: define MEM_ARB_WPROT_EN.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int RD_LAT    = 1,
  parameter int PROT_BASE = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               err,
  output logic               busy,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_data_in,
  output logic               mem_read_write,
  input  logic [DW-1:0]      mem_data_out
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("mem_access_arbiter: NREQ must be 2..4");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("mem_access_arbiter: RD_LAT must be 1..3");
  end
  if (PROT_BASE < 0 || PROT_BASE > (1 << AW)) begin : g_bad_prot_base
    $error("mem_access_arbiter: PROT_BASE outside address range");
  end

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic            lat_we;
  logic [CW-1:0]   cnt;
  logic            prot;

  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   nxt_ptr;
  logic [NREQ-1:0] arb_req;
  logic [IW-1:0]   arb_ptr;
  logic            arb_en;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  assign win_onehot = NREQ'(1) << win;
  assign nxt_ptr    = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

  // The response cycle also arbitrates so the next owner is granted right
  // after ack; the requester being acked still holds req and is masked out.
  always_comb begin
    arb_en  = (state == IDLE) || (state == RESP);
    arb_req = req;
    arb_ptr = ptr;
    if (state == RESP) begin
      arb_req = req & ~win_onehot;
      arb_ptr = nxt_ptr;
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (arb_req),
    .ptr   (arb_ptr),
    .en    (arb_en),
    .grant (arb_gnt),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

`ifdef MEM_ARB_WPROT_EN
  assign prot = int'(mem_addr) >= PROT_BASE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= (state == SETUP) && lat_we && prot;
  end
`else
  assign prot = 1'b0;
  assign err  = 1'b0;
`endif

  // mem_addr / mem_data_in double as the command latch, so they are stable
  // from SETUP through RESP and simply hold in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      win            <= '0;
      lat_we         <= 1'b0;
      cnt            <= '0;
      gnt            <= '0;
      ack            <= '0;
      busy           <= 1'b0;
      mem_read_write <= 1'b0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      rdata          <= '0;
    end else begin
      gnt            <= '0;
      ack            <= '0;
      mem_read_write <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (state == RESP) ptr <= nxt_ptr;
          if (|arb_gnt) begin
            win         <= arb_idx;
            lat_we      <= sel_we;
            mem_addr    <= sel_addr;
            mem_data_in <= sel_wdata;
            gnt         <= arb_gnt;
            busy        <= 1'b1;
            state       <= SETUP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SETUP: begin
          if (lat_we && prot) begin
            ack   <= win_onehot;
            state <= RESP;
          end else if (lat_we) begin
            mem_read_write <= 1'b1;
            state          <= STROBE;
          end else begin
            cnt   <= CW'(RD_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata <= mem_data_out;
            ack   <= win_onehot;
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          ack   <= win_onehot;
          state <= RESP;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter with a behavioural 32x8 memory
// and a transaction-level timing/round-robin reference model.
module tb_mem_access_arbiter;

  localparam int NREQ      = 2;
  localparam int AW        = 5;
  localparam int DW        = 8;
  localparam int RD_LAT    = 1;
  localparam int PROT_BASE = 24;
`ifdef MEM_ARB_WPROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    we = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               err;
  logic               busy;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_data_in;
  logic               mem_read_write;
  logic [DW-1:0]      mem_data_out;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .PROT_BASE(PROT_BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_read_write(mem_read_write), .mem_data_out(mem_data_out)
  );

  // Scratch memory: synchronous write on the strobe, one-cycle registered read.
  logic [DW-1:0] mem [32];
  bit            mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 32; k++) mem[k] <= '0;
    end else if (mem_read_write) begin
      mem[mem_addr] <= mem_data_in;
    end
    mem_data_out <= mem[mem_addr];
  end

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  typedef struct {
    int            who;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
    bit            exp_err;
  } row_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] ref_mem [32];
  int            ptr_model = 0;
  logic [DW-1:0] cur_rd = '0;
  cmd_t          cmds [NREQ];
  bit            err_at_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ptr_model = 0;
    cur_rd    = '0;
  endtask

  // Raise req for every requester in act simultaneously (commands from cmds)
  // and check every cycle against the predicted transaction timeline.
  task automatic run_batch(input logic [NREQ-1:0] act);
    int gc [NREQ];
    int ac [NREQ];
    int sc [NREQ];
    bit pe [NREQ];
    logic [DW-1:0] rd [NREQ];
    int order [$];
    int t, total, last;
    logic [NREQ-1:0] eg, ea;
    logic ee, erw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    for (int i = 0; i < NREQ; i++) begin
      gc[i] = -1; ac[i] = -1; sc[i] = -1; pe[i] = 1'b0; rd[i] = '0;
    end
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr_model + k) % NREQ;
      if (act[i]) order.push_back(i);
    end
    t = 1;
    last = ptr_model;
    foreach (order[j]) begin
      int i;
      bit p;
      i = order[j];
      p = PROT_ON && cmds[i].w && (int'(cmds[i].a) >= PROT_BASE);
      gc[i] = t;
      pe[i] = p;
      if (cmds[i].w && !p) begin
        sc[i] = t + 1;
        ac[i] = t + 2;
        ref_mem[cmds[i].a] = cmds[i].d;
      end else if (cmds[i].w) begin
        ac[i] = t + 1;
      end else begin
        ac[i] = t + 1 + RD_LAT;
        rd[i] = ref_mem[cmds[i].a];
      end
      t = ac[i] + 1;
      last = i;
    end
    total = t - 1;

    for (int i = 0; i < NREQ; i++) begin
      we[i]             = cmds[i].w;
      addr[i*AW +: AW]  = cmds[i].a;
      wdata[i*DW +: DW] = cmds[i].d;
    end
    req = act;
    err_at_ack = 1'b0;

    for (int c = 1; c <= total + 1; c++) begin
      tick();
      eg = '0; ea = '0; ee = 1'b0; erw = 1'b0; e_addr = '0; e_data = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (gc[i] == c) eg[i] = 1'b1;
        if (ac[i] == c) begin
          ea[i] = 1'b1;
          ee    = pe[i];
          if (!cmds[i].w) cur_rd = rd[i];
        end
        if (sc[i] == c) begin
          erw    = 1'b1;
          e_addr = cmds[i].a;
          e_data = cmds[i].d;
        end
      end
      check("gnt", 32'(gnt), 32'(eg));
      check("ack", 32'(ack), 32'(ea));
      check("err", 32'(err), 32'(ee));
      check("mem_read_write", 32'(mem_read_write), 32'(erw));
      if (erw) begin
        check("strobe mem_addr", 32'(mem_addr), 32'(e_addr));
        check("strobe mem_data_in", 32'(mem_data_in), 32'(e_data));
      end
      check("rdata", 32'(rdata), 32'(cur_rd));
      check("busy", 32'(busy), 32'(c <= total));
      if (|ea) err_at_ack = err;
      req = req & ~ea;
    end
    req = '0;
    if (order.size() > 0) ptr_model = (last + 1) % NREQ;
  endtask

  row_t table_q [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) ref_mem[k] = '0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 mem_clr = 1'b0;
    #5;
    check("reset gnt", 32'(gnt), 0);
    check("reset ack", 32'(ack), 0);
    check("reset err", 32'(err), 0);
    check("reset busy", 32'(busy), 0);
    check("reset mem_read_write", 32'(mem_read_write), 0);
    check("reset mem_addr", 32'(mem_addr), 0);
    check("reset mem_data_in", 32'(mem_data_in), 0);
    check("reset rdata", 32'(rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed single accesses, including both address extremes.
    table_q.push_back('{0, 1'b1, 5'h0A, 8'h5C, 8'h00, 1'b0});
    table_q.push_back('{0, 1'b0, 5'h0A, 8'h00, 8'h5C, 1'b0});
    table_q.push_back('{1, 1'b1, 5'h1F, 8'hFF, 8'h00, 1'b0});
    table_q.push_back('{0, 1'b1, 5'h00, 8'h01, 8'h00, 1'b0});
    table_q.push_back('{1, 1'b0, 5'h1F, 8'h00, 8'hFF, 1'b0});
    table_q.push_back('{0, 1'b0, 5'h00, 8'h00, 8'h01, 1'b0});
    table_q.push_back('{1, 1'b1, 5'h0B, 8'h33, 8'h00, 1'b0});
    table_q.push_back('{1, 1'b0, 5'h0B, 8'h00, 8'h33, 1'b0});
    table_q.push_back('{0, 1'b0, 5'h0A, 8'h00, 8'h5C, 1'b0});
`ifdef MEM_ARB_WPROT_EN
    table_q.push_back('{0, 1'b1, 5'h18, 8'hAA, 8'h00, 1'b1});
    table_q.push_back('{1, 1'b0, 5'h18, 8'h00, 8'h00, 1'b0});
`endif
    foreach (table_q[r]) begin
      for (int i = 0; i < NREQ; i++) cmds[i] = '{1'b0, '0, '0};
      cmds[table_q[r].who] = '{table_q[r].w, table_q[r].a, table_q[r].d};
      run_batch(NREQ'(1) << table_q[r].who);
      if (!table_q[r].w) check("table rdata", 32'(rdata), 32'(table_q[r].exp_rd));
      check("table err", 32'(err_at_ack), 32'(table_q[r].exp_err));
    end

    // Reset during the write strobe: strobe drops at once, access is lost.
    cmds[0] = '{1'b1, 5'h0A, 8'hEE};
    we[0] = 1'b1; addr[0 +: AW] = 5'h0A; wdata[0 +: DW] = 8'hEE;
    req = 2'b01;
    tick();
    check("pre-reset gnt", 32'(gnt), 1);
    tick();
    check("pre-reset strobe", 32'(mem_read_write), 1);
    rst_n = 1'b0;
    #1;
    check("async reset mem_read_write", 32'(mem_read_write), 0);
    check("async reset busy", 32'(busy), 0);
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_model = 0;
    cur_rd    = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post-reset ack", 32'(ack), 0);
      check("post-reset busy", 32'(busy), 0);
    end
    cmds[1] = '{1'b0, 5'h0A, 8'h00};
    run_batch(2'b10);
    check("abandoned write left memory", 32'(rdata), 32'h5C);

    // Continuous contention from reset: grants alternate back to back.
    begin
      int gidx [$];
      int gcyc [$];
      int acyc [$];
      do_reset();
      cmds[0] = '{1'b0, 5'h00, 8'h00};
      cmds[1] = '{1'b0, 5'h1F, 8'h00};
      we = '0; addr = {5'h1F, 5'h00};
      req = 2'b11;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (|gnt) begin
          gidx.push_back(gnt[1] ? 1 : 0);
          gcyc.push_back(c);
        end
        if (|ack) acyc.push_back(c);
      end
      req = '0;
      check("contention grant count", 32'(gidx.size() >= 4), 1);
      for (int k = 0; k < 4 && k < gidx.size(); k++)
        check("contention grant order", 32'(gidx[k]), 32'(k % 2));
      for (int k = 1; k < 4 && k < gcyc.size() && k - 1 < acyc.size(); k++)
        check("contention grant after ack", 32'(gcyc[k]), 32'(acyc[k-1] + 1));
      do_reset();
    end

    // Randomized accesses, single and simultaneous.
    for (int n = 0; n < 40; n++) begin
      logic [NREQ-1:0] act;
      act = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        cmds[i] = '{1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom_range(0, 255))};
      run_batch(act);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
